// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared definitions for the LFSR random-source sequencer.
//   - arb_state_t : sequencer FSM encoding (WARM / READY / SEED)
//   - LFSR_DW     : default LFSR output width
//   - LFSR_LOCKUP / LFSR_LOCKUP_FIX and seed_guard(): keep the XNOR LFSR
//     out of its all-ones lockup state when it is seeded.
package lfsr_pkg;

  localparam int          LFSR_DW         = 40;
  localparam logic [31:0] LFSR_LOCKUP     = 32'hFFFF_FFFF;
  localparam logic [31:0] LFSR_LOCKUP_FIX = 32'hFFFF_FFFE;

  typedef enum logic [1:0] {
    ST_WARM  = 2'd0,
    ST_READY = 2'd1,
    ST_SEED  = 2'd2
  } arb_state_t;

  // An all-ones seed would freeze XNOR feedback; nudge it one bit off.
  function automatic logic [31:0] seed_guard(input logic [31:0] s);
    return (s == LFSR_LOCKUP) ? LFSR_LOCKUP_FIX : s;
  endfunction

endpackage

// File: rtl/lfsr_rand_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick.
//   req   in  NREQ   request vector
//   ptr   in  IDW    highest-priority index (always < NREQ)
//   valid out 1      any request set
//   idx   out IDW    first set request at or after ptr, wrapping
// The pointer register lives in the parent.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            valid,
  output logic [IDW-1:0]  idx
);

  logic [NREQ-1:0] rot;
  logic [IDW-1:0]  off;
  logic [IDW:0]    sum;

  assign valid = |req;

  // Rotate so ptr lands at bit 0, take the lowest set bit, then rotate back.
  always_comb begin
    rot = NREQ'({req, req} >> ptr);
    off = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) off = IDW'(k);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    idx = (sum >= (IDW+1)'(NREQ)) ? IDW'(sum - (IDW+1)'(NREQ)) : sum[IDW-1:0];
  end

endmodule

// File: rtl/lfsr_rand_arbiter.sv
// lfsr_rand_arbiter: shares one XNOR LFSR among NREQ sampling lanes.
// After reset or a reseed the LFSR free-runs for WARMUP cycles before any
// draw; consecutive draws are at least STRIDE cycles apart so each word
// carries fresh bits. Requesters are served round-robin.
//   clk, rst_n      clock, async active-low reset
//   seed_req/val    1-cycle reseed pulse and value
//   busy            1 while seeding / warming up
//   req  [NREQ]     level requests, held until ack
//   ack  [NREQ]     one-hot 1-cycle grant pulse
//   rnd_data/rnd_id word and lane of the last grant (held between acks)
//   draw_cnt        grants since reset (wraps)
//   lfsr_seed_en/in to the LFSR seed port
//   lfsr_dout       from the LFSR
module lfsr_rand_arbiter
  import lfsr_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DW     = LFSR_DW,
  parameter int STRIDE = 32,
  parameter int WARMUP = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     seed_req,
  input  logic [31:0]              seed_val,
  output logic                     busy,
  input  logic [NREQ-1:0]          req,
  output logic [NREQ-1:0]          ack,
  output logic [DW-1:0]            rnd_data,
  output logic [$clog2(NREQ)-1:0]  rnd_id,
  output logic [31:0]              draw_cnt,
  output logic                     lfsr_seed_en,
  output logic [31:0]              lfsr_seed_in,
  input  logic [DW-1:0]            lfsr_dout
);

  localparam int IDW = $clog2(NREQ);
  localparam int SW  = $clog2(STRIDE + 1);
  localparam int WW  = $clog2(WARMUP + 1);

  arb_state_t       state_q, state_d;
  logic [WW-1:0]    warm_cnt;
  logic [SW-1:0]    stride_cnt;
  logic [IDW-1:0]   ptr;
  logic [31:0]      seed_q;
  logic             grant;
  logic             ack_vld;
  logic             pick_vld;
  logic [IDW-1:0]   pick_idx;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_WARM;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    unique case (state_q)
      ST_WARM:  if (warm_cnt == '0) state_d = ST_READY;
      ST_READY: grant = (stride_cnt == '0) && pick_vld;
      ST_SEED:  state_d = ST_WARM;
      default:  state_d = ST_WARM;
    endcase
    // A reseed pre-empts everything, including a grant in the same cycle.
    if (seed_req) begin
      state_d = ST_SEED;
      grant   = 1'b0;
    end
  end

  // ---------------- counters / pointer ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm_cnt   <= WW'(WARMUP - 1);
      stride_cnt <= '0;
      ptr        <= '0;
      seed_q     <= '0;
    end else begin
      // Reloaded both on the request and in SEED so a reseed during SEED
      // still enters WARM with a full count.
      if (seed_req || state_q == ST_SEED)
        warm_cnt <= WW'(WARMUP - 1);
      else if (state_q == ST_WARM && warm_cnt != '0)
        warm_cnt <= warm_cnt - 1'b1;

      // Outside READY the stride is parked at 0 so the first READY cycle
      // is immediately eligible.
      if (state_q != ST_READY || seed_req)
        stride_cnt <= '0;
      else if (grant)
        stride_cnt <= SW'(STRIDE - 1);
      else if (stride_cnt != '0)
        stride_cnt <= stride_cnt - 1'b1;

      if (grant)
        ptr <= (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;

      if (seed_req)
        seed_q <= seed_guard(seed_val);
    end
  end

  // ---------------- grant response ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_vld  <= 1'b0;
      rnd_data <= '0;
      rnd_id   <= '0;
      draw_cnt <= '0;
    end else begin
      ack_vld <= grant;
      if (grant) begin
        rnd_data <= lfsr_dout;
        rnd_id   <= pick_idx;
        draw_cnt <= draw_cnt + 32'd1;
      end
    end
  end

  assign ack          = ack_vld ? (NREQ'(1) << rnd_id) : '0;
  assign busy         = (state_q != ST_READY);
  assign lfsr_seed_en = (state_q == ST_SEED);
  assign lfsr_seed_in = seed_q;

endmodule

// File: tb/tb_lfsr_rand_arbiter.sv
// Bench for lfsr_rand_arbiter. A 40-bit XNOR LFSR sits beside the DUT as
// environment. A reference model tracks the spec rules in absolute cycle
// numbers (ready-from cycle, earliest next grant) and pushes expected acks
// and seed-port events into queues; a monitor pops and compares them.
module tb_lfsr_rand_arbiter;
  localparam int NREQ = 4, DW = 40, STRIDE = 32, WARMUP = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              seed_req;
  logic [31:0]       seed_val;
  logic              busy;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   ack;
  logic [DW-1:0]     rnd_data;
  logic [1:0]        rnd_id;
  logic [31:0]       draw_cnt;
  logic              lfsr_seed_en;
  logic [31:0]       lfsr_seed_in;
  logic [DW-1:0]     lfsr_dout;

  always #5 clk = ~clk;

  lfsr_rand_arbiter #(.NREQ(NREQ), .DW(DW), .STRIDE(STRIDE), .WARMUP(WARMUP)) dut (
    .clk(clk), .rst_n(rst_n), .seed_req(seed_req), .seed_val(seed_val),
    .busy(busy), .req(req), .ack(ack), .rnd_data(rnd_data), .rnd_id(rnd_id),
    .draw_cnt(draw_cnt), .lfsr_seed_en(lfsr_seed_en), .lfsr_seed_in(lfsr_seed_in),
    .lfsr_dout(lfsr_dout)
  );

  // environment LFSR
  logic [DW-1:0] lfsr;
  assign lfsr_dout = lfsr;
  always @(posedge clk or negedge rst_n)
    if (!rst_n)            lfsr <= '0;
    else if (lfsr_seed_en) lfsr <= {8'h00, lfsr_seed_in};
    else                   lfsr <= {lfsr[DW-2:0], ~(lfsr[39] ^ lfsr[37] ^ lfsr[20] ^ lfsr[18])};

  int total = 0, bad = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h @%0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  typedef struct { int unsigned cyc; int unsigned id; logic [DW-1:0] data; logic [31:0] cnt; } exp_t;
  typedef struct { int unsigned cyc; logic [31:0] val; } seed_t;
  exp_t  exp_q[$];
  seed_t seed_q[$];
  int unsigned t, ready_from, next_ok, ptr;
  logic [31:0]   draws;
  logic [DW-1:0] last_data;
  logic [31:0]   last_cnt;
  int unsigned   last_id;

  function automatic int unsigned winner(input logic [NREQ-1:0] r, input int unsigned p);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return 0;
  endfunction

  task automatic model_reset();
    t = 0; ready_from = WARMUP; next_ok = 0; ptr = 0; draws = 0;
    exp_q.delete(); seed_q.delete();
    last_data = '0; last_cnt = '0; last_id = 0;
  endtask

  initial begin
    exp_t  e;
    seed_t s;
    int unsigned w;
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else begin
        if (seed_req) begin
          s.cyc = t + 1;
          s.val = (seed_val == 32'hFFFF_FFFF) ? 32'hFFFF_FFFE : seed_val;
          seed_q.push_back(s);
          ready_from = t + 2 + WARMUP;   // 1 SEED cycle + WARMUP cycles
          next_ok    = 0;
        end else if (t >= ready_from && t >= next_ok && req != '0) begin
          w = winner(req, ptr);
          draws = draws + 1;
          e.cyc = t + 1; e.id = w; e.data = lfsr; e.cnt = draws;
          exp_q.push_back(e);
          ptr     = (w + 1) % NREQ;
          next_ok = t + STRIDE;
        end
        t++;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("busy", busy, (t < ready_from));
        if (seed_q.size() > 0 && seed_q[0].cyc == t) begin
          chk("seed_en", lfsr_seed_en, 1);
          chk("seed_in", lfsr_seed_in, seed_q[0].val);
          void'(seed_q.pop_front());
        end else
          chk("seed_en_idle", lfsr_seed_en, 0);
        if (exp_q.size() > 0 && exp_q[0].cyc == t) begin
          e = exp_q.pop_front();
          chk("ack", ack, 64'(1) << e.id);
          chk("rnd_id", rnd_id, e.id);
          chk("rnd_data", rnd_data, e.data);
          chk("draw_cnt", draw_cnt, e.cnt);
          last_data = e.data; last_cnt = e.cnt; last_id = e.id;
        end else begin
          chk("ack_idle", ack, 0);
          chk("rnd_data_hold", rnd_data, last_data);
          chk("rnd_id_hold", rnd_id, last_id);
          chk("draw_cnt_hold", draw_cnt, last_cnt);
        end
      end
    end
  end

  // ---------------- requester driver ----------------
  logic [NREQ-1:0] mask, pulse;
  initial begin
    req = '0;
    forever begin
      @(negedge clk);
      #1 req = (mask & ~ack) | pulse;   // acked lane drops for a cycle
    end
  end

  // ---------------- stimulus ----------------
  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_busy", busy, 1);
    chk("rst_ack", ack, 0);
    chk("rst_rnd_data", rnd_data, 0);
    chk("rst_rnd_id", rnd_id, 0);
    chk("rst_draw_cnt", draw_cnt, 0);
    chk("rst_seed_en", lfsr_seed_en, 0);
    chk("rst_seed_in", lfsr_seed_in, 0);
  endtask

  task automatic wait_elig();
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (t >= ready_from && t >= next_ok) begin ok = 1; break; end
    end
    chk("wait_eligible_timeout", ok, 1);
  endtask

  task automatic wait_ack(input int lane);
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ack[lane]) begin ok = 1; break; end
    end
    chk("wait_ack_timeout", ok, 1);
  endtask

  task automatic seed(input logic [31:0] v);
    seed_val = v; seed_req = 1'b1;
    @(negedge clk);
    seed_req = 1'b0;
  endtask

  initial begin
    seed_req = 0; seed_val = '0; mask = '0; pulse = '0;
    run(3);
    chk_reset_outputs();

    // single requester from reset: first ack after warm-up
    mask = 4'b0001; rst_n = 1'b1;
    run(100);
    // all requesting: round-robin at STRIDE spacing
    mask = 4'b1111;
    run(200);
    // reseed colliding with an eligible request, twice with the same value
    wait_elig(); seed(32'h1234_5678); run(150);
    wait_elig(); seed(32'h1234_5678); run(150);
    // lockup guard
    seed(32'hFFFF_FFFF); run(120);
    // dropped request is not served; pointer still advances past winner
    mask = 4'b0010;
    wait_ack(1);
    mask = 4'b0000; pulse = 4'b0100;
    @(negedge clk);
    pulse = '0;
    run(40);
    mask = 4'b0101;
    run(100);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) mask = 4'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        seed_val = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
        seed_req = 1'b1;
      end else seed_req = 1'b0;
      pulse = ($urandom_range(0, 19) == 0) ? 4'($urandom) : 4'b0000;
    end
    seed_req = 0; pulse = '0;

    // async reset in the middle of a stride
    mask = 4'b1111;
    wait_elig();
    wait_ack(0);
    run(5);
    #3 rst_n = 1'b0;
    #1 chk_reset_outputs();
    run(2);
    rst_n = 1'b1; mask = 4'b0001;
    run(100);

    mask = '0;
    run(40);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("seed_q_drained", seed_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
